// File: rtl/a2bus_capture_fifo_if.sv
// ---------------------------------------------------------------------------
// a2bus_capture_fifo_if
// Groups the bus-snoop inputs, window programming port, packet stream and
// status of a2bus_capture_fifo.
//   slave  : capture block side (bus/cfg/ready/stat_clear in; stream/status out)
//   master : driver side (the mirror image)
// Parameters must match the ones given to a2bus_capture_fifo.
// ---------------------------------------------------------------------------
interface a2bus_capture_fifo_if #(
    parameter int DEPTH_LOG2 = 5,
    parameter int TS_W       = 16
);
    localparam int PKT_W = 32 + TS_W;

    logic                  bus_strobe;
    logic                  bus_m2sel_n;
    logic [15:0]           bus_addr;
    logic [7:0]            bus_data;
    logic                  bus_rw_n;
    logic                  bus_m2b0;
    logic                  bus_sw_gs;
    logic                  capture_enable;

    logic                  cfg_wr;
    logic [2:0]            cfg_idx;
    logic [15:0]           cfg_base;
    logic [15:0]           cfg_mask;
    logic [1:0]            cfg_rw;
    logic                  cfg_en;

    logic                  out_valid;
    logic [PKT_W-1:0]      out_data;
    logic                  out_ready;

    logic [DEPTH_LOG2:0]   fifo_level;
    logic [15:0]           drop_count;
    logic                  overflow_sticky;
    logic                  stat_clear;

    modport slave (
        input  bus_strobe, bus_m2sel_n, bus_addr, bus_data, bus_rw_n,
               bus_m2b0, bus_sw_gs, capture_enable,
               cfg_wr, cfg_idx, cfg_base, cfg_mask, cfg_rw, cfg_en,
               out_ready, stat_clear,
        output out_valid, out_data, fifo_level, drop_count, overflow_sticky
    );

    modport master (
        output bus_strobe, bus_m2sel_n, bus_addr, bus_data, bus_rw_n,
               bus_m2b0, bus_sw_gs, capture_enable,
               cfg_wr, cfg_idx, cfg_base, cfg_mask, cfg_rw, cfg_en,
               out_ready, stat_clear,
        input  out_valid, out_data, fifo_level, drop_count, overflow_sticky
    );
endinterface

// File: rtl/a2bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// a2bus_capture_fifo
// Snoops bus transactions, filters them through NUM_WIN address/rw windows
// and queues matching ones as timestamped packets in a first-word
// fall-through FIFO with drop accounting.
// Ports:
//   clk_logic : sole clock
//   reset     : synchronous, active-high
//   bus       : a2bus_capture_fifo_if.slave (bus fields, window cfg port,
//               ready/valid packet stream, level/drop status)
// Packet: {ts, addr[15:0], data[7:0], rw_n, m2sel_n, m2b0, sw_gs, win[2:0], marker}
// Optional feature: define A2BUS_CAPTURE_DROP_MARKER_EN to emit a marker
// packet carrying the drop-run length once space frees up after drops.
// ---------------------------------------------------------------------------
module a2bus_capture_fifo #(
    parameter int NUM_WIN    = 4,
    parameter int DEPTH_LOG2 = 5,
    parameter int TS_W       = 16
) (
    input  logic                clk_logic,
    input  logic                reset,
    a2bus_capture_fifo_if.slave bus
);
    localparam int PKT_W = 32 + TS_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    function automatic logic rw_pass(input logic [1:0] rw_sel, input logic rw_n);
        case (rw_sel)
            2'b00:   return 1'b1;
            2'b01:   return rw_n;
            2'b10:   return !rw_n;
            default: return 1'b0;
        endcase
    endfunction

    logic [TS_W-1:0]       ts_q;
    logic [15:0]           base_q [NUM_WIN];
    logic [15:0]           mask_q [NUM_WIN];
    logic [1:0]            rw_q   [NUM_WIN];
    logic [NUM_WIN-1:0]    en_q;

    logic [PKT_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  sticky_q, sticky_d;

    logic [NUM_WIN-1:0]    win_hit;
    logic                  hit;
    logic [2:0]            win_idx;
    logic                  capture, pop, space, push, drop;
    logic [PKT_W-1:0]      push_data, bus_pkt;

    always_comb begin
        win_hit = '0;
        hit     = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            win_hit[i] = en_q[i]
                && ((bus.bus_addr & mask_q[i]) == (base_q[i] & mask_q[i]))
                && rw_pass(rw_q[i], bus.bus_rw_n);
        end
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                hit     = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    assign capture = bus.capture_enable & bus.bus_strobe & ~bus.bus_m2sel_n & hit;
    assign pop     = bus.out_valid & bus.out_ready;
    // A pop in the same cycle frees the slot a push needs.
    assign space   = (level_q != LEVEL_FULL) | pop;
    assign bus_pkt = {ts_q, bus.bus_addr, bus.bus_data, bus.bus_rw_n, bus.bus_m2sel_n,
                      bus.bus_m2b0, bus.bus_sw_gs, win_idx, 1'b0};

`ifdef A2BUS_CAPTURE_DROP_MARKER_EN
    logic       pend_q, pend_d;
    logic [7:0] run_q, run_d;

    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        push_data = bus_pkt;
        pend_d    = pend_q;
        run_d     = run_q;
        if (pend_q && space) begin
            // Marker owns this slot; a capture arriving now opens a new drop run.
            push      = 1'b1;
            push_data = {ts_q, 16'hFFFF, run_q, 4'b0000, 3'b111, 1'b1};
            pend_d    = 1'b0;
            run_d     = '0;
            if (capture) begin
                drop   = 1'b1;
                pend_d = 1'b1;
                run_d  = 8'd1;
            end
        end else if (capture) begin
            if (space) begin
                push = 1'b1;
            end else begin
                drop   = 1'b1;
                pend_d = 1'b1;
                if (run_q != 8'hFF) run_d = run_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            pend_q <= 1'b0;
            run_q  <= '0;
        end else begin
            pend_q <= pend_d;
            run_q  <= run_d;
        end
    end
`else
    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        push_data = bus_pkt;
        if (capture) begin
            if (space) push = 1'b1;
            else       drop = 1'b1;
        end
    end
`endif

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        sticky_d   = sticky_q;
        if (bus.stat_clear) begin
            drop_cnt_d = {15'd0, drop};
            sticky_d   = drop;
        end else if (drop) begin
            sticky_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            sticky_q   <= 1'b0;
            en_q       <= '0;
            for (int i = 0; i < NUM_WIN; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                rw_q[i]   <= '0;
            end
        end else begin
            ts_q       <= ts_q + 1'b1;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            sticky_q   <= sticky_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (bus.cfg_wr && bus.cfg_idx == 3'(i)) begin
                    base_q[i] <= bus.cfg_base;
                    mask_q[i] <= bus.cfg_mask;
                    rw_q[i]   <= bus.cfg_rw;
                    en_q[i]   <= bus.cfg_en;
                end
            end
        end
    end

    // Storage needs no reset: pointers and level decide what is visible.
    always_ff @(posedge clk_logic) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.out_valid       = (level_q != '0);
    assign bus.out_data        = mem_q[rd_ptr_q];
    assign bus.fifo_level      = level_q;
    assign bus.drop_count      = drop_cnt_q;
    assign bus.overflow_sticky = sticky_q;

endmodule

// File: tb/tb_a2bus_capture_fifo.sv
module tb_a2bus_capture_fifo;
    localparam int NUM_WIN    = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int TS_W       = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a2bus_capture_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .TS_W(TS_W)) bus_if ();

    a2bus_capture_fifo #(.NUM_WIN(NUM_WIN), .DEPTH_LOG2(DEPTH_LOG2), .TS_W(TS_W)) dut (
        .clk_logic (clk),
        .reset     (rst),
        .bus       (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [47:0] exp_q[$];
    int          m_drops;
    bit          m_sticky;
    logic [15:0] m_ts;
    logic [15:0] m_base [NUM_WIN];
    logic [15:0] m_mask [NUM_WIN];
    logic [1:0]  m_rw   [NUM_WIN];
    bit          m_en   [NUM_WIN];
    bit          m_pend;
    int          m_run;

    function automatic bit rw_ok(input logic [1:0] sel, input logic rw_n);
        if (sel == 2'd0) return 1'b1;
        if (sel == 2'd1) return rw_n == 1'b1;
        if (sel == 2'd2) return rw_n == 1'b0;
        return 1'b0;
    endfunction

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        bit fnd, cap, pop, space, drop;
        int w;
        logic [47:0] bp;
        if (rst) begin
            exp_q.delete();
            m_drops = 0; m_sticky = 0; m_ts = '0; m_pend = 0; m_run = 0;
            for (int i = 0; i < NUM_WIN; i++) begin
                m_en[i] = 0; m_base[i] = '0; m_mask[i] = '0; m_rw[i] = '0;
            end
        end else begin
            fnd = 0; w = 0;
            for (int i = 0; i < NUM_WIN; i++)
                if (!fnd && m_en[i] && ((bus_if.bus_addr & m_mask[i]) == (m_base[i] & m_mask[i]))
                    && rw_ok(m_rw[i], bus_if.bus_rw_n)) begin
                    fnd = 1; w = i;
                end
            cap   = bus_if.capture_enable && bus_if.bus_strobe && !bus_if.bus_m2sel_n && fnd;
            pop   = exp_q.size() > 0 && bus_if.out_ready;
            space = exp_q.size() < DEPTH || pop;
            bp    = {m_ts, bus_if.bus_addr, bus_if.bus_data, bus_if.bus_rw_n, 1'b0,
                     bus_if.bus_m2b0, bus_if.bus_sw_gs, 3'(w), 1'b0};
            if (pop) void'(exp_q.pop_front());
            drop = 0;
`ifdef A2BUS_CAPTURE_DROP_MARKER_EN
            if (m_pend && space) begin
                exp_q.push_back({m_ts, 16'hFFFF, 8'(m_run), 4'b0000, 3'b111, 1'b1});
                m_pend = 0; m_run = 0;
                if (cap) begin drop = 1; m_pend = 1; m_run = 1; end
            end else if (cap) begin
                if (space) exp_q.push_back(bp);
                else begin drop = 1; m_pend = 1; if (m_run < 255) m_run++; end
            end
`else
            if (cap) begin
                if (space) exp_q.push_back(bp);
                else drop = 1;
            end
`endif
            if (bus_if.stat_clear) begin
                m_drops = drop ? 1 : 0; m_sticky = drop;
            end else if (drop) begin
                if (m_drops < 65535) m_drops++;
                m_sticky = 1;
            end
            if (bus_if.cfg_wr && int'(bus_if.cfg_idx) < NUM_WIN) begin
                m_base[bus_if.cfg_idx] = bus_if.cfg_base;
                m_mask[bus_if.cfg_idx] = bus_if.cfg_mask;
                m_rw[bus_if.cfg_idx]   = bus_if.cfg_rw;
                m_en[bus_if.cfg_idx]   = bus_if.cfg_en;
            end
            m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus_if.bus_strobe = 0; bus_if.bus_m2sel_n = 0; bus_if.bus_addr = '0; bus_if.bus_data = '0;
        bus_if.bus_rw_n = 1; bus_if.bus_m2b0 = 0; bus_if.bus_sw_gs = 0; bus_if.capture_enable = 1;
        bus_if.cfg_wr = 0; bus_if.cfg_idx = '0; bus_if.cfg_base = '0; bus_if.cfg_mask = '0;
        bus_if.cfg_rw = '0; bus_if.cfg_en = 0; bus_if.stat_clear = 0;
    endtask

    task automatic set_strobe(input logic [15:0] a, input logic [7:0] d, input logic rw_n);
        bus_if.bus_strobe = 1; bus_if.bus_addr = a; bus_if.bus_data = d; bus_if.bus_rw_n = rw_n;
        bus_if.bus_m2b0 = 1'($urandom); bus_if.bus_sw_gs = 1'($urandom);
    endtask

    task automatic cfg_win(input int idx, input logic [15:0] b, input logic [15:0] m,
                           input logic [1:0] rw, input logic en);
        bus_if.cfg_wr = 1; bus_if.cfg_idx = 3'(idx); bus_if.cfg_base = b; bus_if.cfg_mask = m;
        bus_if.cfg_rw = rw; bus_if.cfg_en = en;
        tick();
        bus_if.cfg_wr = 0;
    endtask

    task automatic test_reset();
        set_idle();
        bus_if.out_ready = 0;
        rst = 1; tick(); tick(); rst = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus_if.out_valid); end
        n_tests++; if (bus_if.fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus_if.fifo_level); end
        n_tests++; if (bus_if.drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drops got %0d exp 0", bus_if.drop_count); end
        n_tests++; if (bus_if.overflow_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b exp 0", bus_if.overflow_sticky); end
    endtask

    task automatic test_basic();
        cfg_win(0, 16'hC03C, 16'hFFFC, 2'b00, 1);
        set_strobe(16'hC03D, 8'h5A, 1);
        tick();
        bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", bus_if.out_valid); end
        n_tests++; if (bus_if.out_data[31:16] !== 16'hC03D) begin n_fail++; $display("FAIL basic_addr got %h exp C03D", bus_if.out_data[31:16]); end
        n_tests++; if (bus_if.out_data[15:8] !== 8'h5A) begin n_fail++; $display("FAIL basic_data got %h exp 5A", bus_if.out_data[15:8]); end
        n_tests++; if (bus_if.out_data[7] !== 1'b1) begin n_fail++; $display("FAIL basic_rw got %b exp 1", bus_if.out_data[7]); end
        n_tests++; if (bus_if.out_data[3:0] !== 4'b0000) begin n_fail++; $display("FAIL basic_win_marker got %b exp 0000", bus_if.out_data[3:0]); end
        n_tests++; if (bus_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL basic_pkt got %h exp %h", bus_if.out_data, exp_q[0]); end
        bus_if.out_ready = 1; tick(); bus_if.out_ready = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %b exp 0", bus_if.out_valid); end
    endtask

    task automatic test_priority();
        cfg_win(0, 16'hC030, 16'hFFF0, 2'b00, 1);
        cfg_win(2, 16'hC000, 16'hFF00, 2'b00, 1);
        set_strobe(16'hC030, 8'h11, 1); tick(); bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_data[3:1] !== 3'd0 || bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_low got win %0d v %b exp win 0 v 1", bus_if.out_data[3:1], bus_if.out_valid); end
        bus_if.out_ready = 1; tick(); bus_if.out_ready = 0;
        cfg_win(0, 16'hC030, 16'hFFF0, 2'b00, 0);
        set_strobe(16'hC030, 8'h22, 1); tick(); bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_data[3:1] !== 3'd2 || bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_dis got win %0d v %b exp win 2 v 1", bus_if.out_data[3:1], bus_if.out_valid); end
        bus_if.out_ready = 1; tick(); bus_if.out_ready = 0;
        cfg_win(1, 16'hD000, 16'hF000, 2'b10, 1);
        set_strobe(16'hD123, 8'h33, 1); tick(); bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_filter_read got %b exp 0", bus_if.out_valid); end
        set_strobe(16'hD123, 8'h44, 0); tick(); bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_data[3:1] !== 3'd1 || bus_if.out_data[7] !== 1'b0 || bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rw_filter_write got win %0d rw %b v %b exp 1 0 1", bus_if.out_data[3:1], bus_if.out_data[7], bus_if.out_valid); end
        bus_if.out_ready = 1; tick(); bus_if.out_ready = 0;
        cfg_win(5, 16'hE000, 16'hF000, 2'b00, 1);
        set_strobe(16'hE000, 8'h55, 1); tick(); bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_idx_oob got %b exp 0", bus_if.out_valid); end
        bus_if.capture_enable = 0; set_strobe(16'hC030, 8'h66, 1); tick();
        bus_if.capture_enable = 1; bus_if.bus_m2sel_n = 1; tick();
        bus_if.bus_m2sel_n = 0; bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_sel got %b exp 0", bus_if.out_valid); end
    endtask

    task automatic test_overflow();
        logic [47:0] held;
        cfg_win(0, 16'hC03C, 16'hFFFC, 2'b00, 1);
        for (int i = 0; i < 6; i++) begin set_strobe(16'hC03C, 8'($urandom), 1); tick(); end
        bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d exp 4", bus_if.fifo_level); end
        n_tests++; if (bus_if.drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drops got %0d exp 2", bus_if.drop_count); end
        n_tests++; if (bus_if.overflow_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus_if.overflow_sticky); end
        held = bus_if.out_data;
        n_tests++; if (held !== exp_q[0]) begin n_fail++; $display("FAIL ovf_head got %h exp %h", held, exp_q[0]); end
        tick();
        n_tests++; if (bus_if.out_data !== held) begin n_fail++; $display("FAIL hold_stable got %h exp %h", bus_if.out_data, held); end
        bus_if.out_ready = 1; set_strobe(16'hC03C, 8'h77, 1); tick();
        bus_if.out_ready = 0; bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_poppush_level got %0d exp 4", bus_if.fifo_level); end
`ifdef A2BUS_CAPTURE_DROP_MARKER_EN
        n_tests++; if (bus_if.drop_count !== 16'd3) begin n_fail++; $display("FAIL full_poppush_drops got %0d exp 3", bus_if.drop_count); end
`else
        n_tests++; if (bus_if.drop_count !== 16'd2) begin n_fail++; $display("FAIL full_poppush_drops got %0d exp 2", bus_if.drop_count); end
`endif
        bus_if.stat_clear = 1; tick();
        n_tests++; if (bus_if.drop_count !== 16'd0 || bus_if.overflow_sticky !== 1'b0) begin n_fail++; $display("FAIL stat_clear got %0d/%b exp 0/0", bus_if.drop_count, bus_if.overflow_sticky); end
        set_strobe(16'hC03C, 8'h88, 1); tick();
        bus_if.bus_strobe = 0; bus_if.stat_clear = 0;
        n_tests++; if (bus_if.drop_count !== 16'd1 || bus_if.overflow_sticky !== 1'b1) begin n_fail++; $display("FAIL clear_with_drop got %0d/%b exp 1/1", bus_if.drop_count, bus_if.overflow_sticky); end
        bus_if.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (bus_if.fifo_level !== 3'(exp_q.size())) begin n_fail++; $display("FAIL drain_level got %0d exp %0d", bus_if.fifo_level, exp_q.size()); end
            if (exp_q.size() != 0) begin
                n_tests++; if (bus_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL drain_data got %h exp %h", bus_if.out_data, exp_q[0]); end
            end
            tick();
        end
        bus_if.out_ready = 0;
        bus_if.stat_clear = 1; tick(); bus_if.stat_clear = 0;
    endtask

    task automatic test_marker();
        logic [47:0] obs[$];
        bit any_marker;
        for (int i = 0; i < 7; i++) begin set_strobe(16'hC03C, 8'(i), 1); tick(); end
        bus_if.bus_strobe = 0;
        n_tests++; if (bus_if.drop_count !== 16'd3) begin n_fail++; $display("FAIL mk_drops got %0d exp 3", bus_if.drop_count); end
        bus_if.out_ready = 1; tick();
        set_strobe(16'hC03C, 8'hAA, 1); tick(); bus_if.bus_strobe = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.out_valid === 1'b1) begin
                obs.push_back(bus_if.out_data);
                n_tests++; if (exp_q.size() == 0 || bus_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL mk_seq got %h exp %h", bus_if.out_data, (exp_q.size() != 0) ? exp_q[0] : 48'h0); end
            end
            tick();
        end
        bus_if.out_ready = 0;
        any_marker = 0;
        foreach (obs[i]) if (obs[i][0]) any_marker = 1;
`ifdef A2BUS_CAPTURE_DROP_MARKER_EN
        n_tests++; if (obs.size() != 4) begin n_fail++; $display("FAIL mk_count got %0d exp 4", obs.size()); end
        if (obs.size() == 4) begin
            n_tests++; if (obs[2][31:0] !== 32'hFFFF_030F) begin n_fail++; $display("FAIL mk_fields got %h exp FFFF030F", obs[2][31:0]); end
            n_tests++; if (obs[3][15:8] !== 8'hAA || obs[3][0] !== 1'b0) begin n_fail++; $display("FAIL mk_after got %h exp data AA marker 0", obs[3][15:0]); end
        end
`else
        n_tests++; if (obs.size() != 3) begin n_fail++; $display("FAIL nomk_count got %0d exp 3", obs.size()); end
        n_tests++; if (any_marker) begin n_fail++; $display("FAIL nomk_marker got 1 exp 0"); end
        if (obs.size() == 3) begin
            n_tests++; if (obs[2][15:8] !== 8'hAA) begin n_fail++; $display("FAIL nomk_last got %h exp AA", obs[2][15:8]); end
        end
`endif
        bus_if.stat_clear = 1; tick(); bus_if.stat_clear = 0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin set_strobe(16'hC03C, 8'(8'hB0 + i), 1); tick(); end
        bus_if.bus_strobe = 0;
        rst = 1; tick(); rst = 0;
        n_tests++; if (bus_if.out_valid !== 1'b0 || bus_if.fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_empty got v %b lvl %0d exp 0 0", bus_if.out_valid, bus_if.fifo_level); end
        n_tests++; if (bus_if.drop_count !== 16'd0 || bus_if.overflow_sticky !== 1'b0) begin n_fail++; $display("FAIL midrst_stats got %0d/%b exp 0/0", bus_if.drop_count, bus_if.overflow_sticky); end
        bus_if.out_ready = 1;
        set_strobe(16'hC03C, 8'hC1, 1); tick(); bus_if.bus_strobe = 0;
        tick(); tick();
        n_tests++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_nocap got %b exp 0", bus_if.out_valid); end
        bus_if.out_ready = 0;
        cfg_win(0, 16'hC03C, 16'hFFFC, 2'b00, 1);
        set_strobe(16'hC03C, 8'hC2, 1); tick(); bus_if.bus_strobe = 0;
        // Cycles after reset release: strobe, two idle, cfg write => capture stamped 4.
        n_tests++; if (bus_if.out_data[47:32] !== 16'd4) begin n_fail++; $display("FAIL midrst_ts got %0d exp 4", bus_if.out_data[47:32]); end
        n_tests++; if (bus_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL midrst_pkt got %h exp %h", bus_if.out_data, exp_q[0]); end
    endtask

    task automatic test_random();
        logic [15:0] masks [5];
        masks[0] = 16'hFFFF; masks[1] = 16'hFFF0; masks[2] = 16'hFF00; masks[3] = 16'hF000; masks[4] = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            set_idle();
            bus_if.out_ready = 1'($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus_if.cfg_wr = 1; bus_if.cfg_idx = 3'($urandom_range(0, 7));
                bus_if.cfg_base = {8'hC0, 8'($urandom)}; bus_if.cfg_mask = masks[$urandom_range(0, 4)];
                bus_if.cfg_rw = 2'($urandom); bus_if.cfg_en = 1'($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                set_strobe(($urandom_range(0, 7) == 0) ? 16'($urandom) : {8'hC0, 8'($urandom)}, 8'($urandom), 1'($urandom));
                bus_if.bus_m2sel_n = 1'($urandom_range(0, 7) == 0);
                bus_if.capture_enable = 1'($urandom_range(0, 7) != 0);
            end
            bus_if.stat_clear = 1'($urandom_range(0, 49) == 0);
            n_tests++; if (bus_if.out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bus_if.out_valid, exp_q.size() != 0); end
            n_tests++; if (bus_if.fifo_level !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", c, bus_if.fifo_level, exp_q.size()); end
            n_tests++; if (bus_if.drop_count !== 16'(m_drops) || bus_if.overflow_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_stats cyc %0d got %0d/%b exp %0d/%b", c, bus_if.drop_count, bus_if.overflow_sticky, m_drops, m_sticky); end
            if (exp_q.size() != 0) begin
                n_tests++; if (bus_if.out_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, bus_if.out_data, exp_q[0]); end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_overflow();
        test_marker();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/a2bus_capture_fifo.md
A2BUS_CAPTURE_FIFO -- requirements
Module: a2bus_capture_fifo

Interface
REQ-001 Parameter NUM_WIN, default 4, is the number of address capture windows (1..8).
REQ-002 Parameter DEPTH_LOG2, default 5, sets FIFO depth as 2**DEPTH_LOG2 packets (2..10).
REQ-003 Parameter TS_W, default 16, is the timestamp width (1..16); PKT_W = 32+TS_W.
REQ-004 clk_logic  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 bus_strobe  in  1  one-cycle data_in_strobe per bus transaction; bus_m2sel_n  in  1  active-low slot/bus select.
REQ-006 bus_addr  in  16; bus_data  in  8; bus_rw_n, bus_m2b0, bus_sw_gs  in  1 each  bus fields, sampled on bus_strobe.
REQ-007 capture_enable  in  1  global capture gate.
REQ-008 cfg_wr  in  1; cfg_idx  in  3; cfg_base, cfg_mask  in  16; cfg_rw  in  2; cfg_en  in  1  window programming port.
REQ-009 out_valid  out  1; out_data  out  PKT_W; out_ready  in  1  ready/valid packet stream.
REQ-010 fifo_level  out  DEPTH_LOG2+1  occupancy; drop_count  out  16  dropped captures; overflow_sticky  out  1; stat_clear  in  1.

Function
REQ-011 Window i SHALL match when enabled and (bus_addr & mask_i) == (base_i & mask_i) and the rw filter passes: cfg_rw 00 both, 01 reads only (rw_n=1), 10 writes only, 11 none.
REQ-012 Capture SHALL occur when capture_enable & bus_strobe & !bus_m2sel_n and at least one window matches; the lowest matching index wins.
REQ-013 Packet layout SHALL be {timestamp[TS_W-1:0], addr[15:0], data[7:0], rw_n, m2sel_n, m2b0, sw_gs, win_idx[2:0], marker}, with marker=0 for bus packets.
REQ-014 Timestamp SHALL be a free-running TS_W counter, +1 per clk_logic, wrapping to 0, sampled in the capture cycle.
REQ-015 A capture in cycle N SHALL be written at the end of cycle N; when the FIFO was empty, out_valid SHALL be high in cycle N+1 (first-word fall-through).
REQ-016 Pop SHALL occur on out_valid & out_ready; out_data SHALL hold stable while out_valid & !out_ready.
REQ-017 Push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the capture is dropped.
REQ-018 Each dropped capture SHALL increment drop_count (saturating at 16'hFFFF) and set overflow_sticky.
REQ-019 stat_clear SHALL zero drop_count and overflow_sticky next cycle; a simultaneous drop SHALL leave drop_count=1 and overflow_sticky=1.
REQ-020 cfg_wr SHALL load base, mask, rw, en of window cfg_idx in one cycle; cfg_idx >= NUM_WIN SHALL be ignored; the new settings apply from the next cycle.
REQ-021 Pointers SHALL wrap modulo depth; fifo_level SHALL equal pushes minus pops and reach exactly 2**DEPTH_LOG2 when full.

Reset
REQ-022 reset SHALL empty the FIFO, drive out_valid=0, fifo_level=0, drop_count=0, overflow_sticky=0, timestamp=0, and all windows to en=0, base=0, mask=0, rw=00.
REQ-023 reset asserted mid-stream SHALL discard all queued packets and any pending marker, with out_valid low in the following cycle.

Configuration
REQ-024 Macro A2BUS_CAPTURE_DROP_MARKER_EN defined: after drops, the first cycle with FIFO space SHALL push a marker packet {timestamp, 16'hFFFF, drop-run count saturated at 8'hFF, 4'b0000, 3'b111, 1'b1} before any further capture; a capture in that same cycle is dropped and counted.
REQ-025 Macro undefined: no marker packets are generated; drops are reported only through drop_count and overflow_sticky.

Verification
REQ-026 Window 0 base C03C mask FFFC rw 00; read strobe at C03D data 5A -> out_valid next cycle, addr C03D, data 5A, win_idx 0, marker 0.
REQ-027 Windows 0 and 2 both match C030 -> win_idx 0; window 0 disabled -> win_idx 2; window 1 rw=10 with a read -> no capture.
REQ-028 DEPTH_LOG2=2, out_ready=0, 6 captures -> fifo_level 4, drop_count 2, overflow_sticky 1; full plus simultaneous pop and push -> level stays 4, no drop.
REQ-029 With marker macro: after 3 drops, out_ready=1 -> marker data 03, addr FFFF, marker 1, queued ahead of the next capture; without macro -> no marker.
REQ-030 Reset with 3 queued packets -> out_valid 0 and fifo_level 0 next cycle; timestamp 0; all windows disabled; strobe at C03C -> no capture.
